// File: rtl/fetch_stage_unit.sv
// fetch_stage_unit: program counter, instruction fetch and IF/ID register.
// Optional counters are enabled with `define FETCH_PERF_CNT_EN.
module fetch_stage_unit #(
  parameter logic [31:0] PC_RESET  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000,
  parameter int          SAT_CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 hazard_detected,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_address,
  input  logic [31:0]          imem_rdata,
  output logic [31:0]          imem_addr,
  output logic [31:0]          id_instruction,
  output logic [31:0]          id_pc,
  output logic                 id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [SAT_CNT_W-1:0] stall_count,
  output logic [SAT_CNT_W-1:0] flush_count
`endif
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } if_id_t;

  localparam logic [31:0] PC_INIT = {PC_RESET[31:2], 2'b00};

  logic [31:0] pc;
  logic [31:0] pc_plus4;
  if_id_t      if_id;
  logic        br_addr_unused;

  assign pc_plus4       = pc + 32'd4;
  assign imem_addr      = pc;
  assign id_instruction = if_id.instr;
  assign id_pc          = if_id.pc;
  assign id_valid       = if_id.valid;
  assign br_addr_unused = ^branch_address[1:0];

  // PC: branch redirect beats stall, stall beats advance
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= PC_INIT;
    end else if (branch_taken) begin
      pc <= {branch_address[31:2], 2'b00};
    end else if (!hazard_detected) begin
      pc <= pc_plus4;
    end
  end

  // IF/ID: flush on branch, hold on stall, capture otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id.instr <= NOP_INSTR;
      if_id.pc    <= 32'd0;
      if_id.valid <= 1'b0;
    end else if (branch_taken) begin
      if_id.instr <= NOP_INSTR;
      if_id.pc    <= 32'd0;
      if_id.valid <= 1'b0;
    end else if (!hazard_detected) begin
      if_id.instr <= imem_rdata;
      if_id.pc    <= pc_plus4;
      if_id.valid <= 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating freeze and flush event counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (branch_taken && !(&flush_count))
        flush_count <= flush_count + SAT_CNT_W'(1);
      if (hazard_detected && !branch_taken && !(&stall_count))
        stall_count <= stall_count + SAT_CNT_W'(1);
    end
  end
`else
  localparam int cnt_w_unused = SAT_CNT_W;
`endif

endmodule

// File: tb/tb_fetch_stage_unit.sv
// tb_fetch_stage_unit: scoreboard bench for fetch_stage_unit.
// Counter checks compile only with FETCH_PERF_CNT_EN.
module tb_fetch_stage_unit;

  localparam logic [31:0] NOP = 32'hE1A0_0000;
  localparam int          CW  = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hazard = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] baddr = 32'd0;
  logic [31:0] imem_rdata, imem_addr;
  logic [31:0] id_instruction, id_pc;
  logic        id_valid;
  logic        w_zero = 1'b0;
  logic [31:0] w_baddr = 32'd0;
  logic [31:0] w_rdata, w_addr, w_instr, w_pc;
  logic        w_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [CW-1:0] stall_count, flush_count, w_stall, w_flush;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] mpc;
  exp_t        cur;
  exp_t        e;
  exp_t        exp_q[$];
  int          exp_stall, exp_flush;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  assign imem_rdata = mem(imem_addr);
  assign w_rdata    = mem(w_addr);

  always #5 clk = ~clk;

  fetch_stage_unit #(.SAT_CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .hazard_detected(hazard), .branch_taken(branch),
    .branch_address(baddr), .imem_rdata(imem_rdata),
    .imem_addr(imem_addr), .id_instruction(id_instruction),
    .id_pc(id_pc), .id_valid(id_valid)
`ifdef FETCH_PERF_CNT_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  fetch_stage_unit #(.PC_RESET(32'hFFFF_FFFC), .SAT_CNT_W(CW)) dut_w (
    .clk(clk), .rst(rst),
    .hazard_detected(w_zero), .branch_taken(w_zero),
    .branch_address(w_baddr), .imem_rdata(w_rdata),
    .imem_addr(w_addr), .id_instruction(w_instr),
    .id_pc(w_pc), .id_valid(w_valid)
`ifdef FETCH_PERF_CNT_EN
    , .stall_count(w_stall), .flush_count(w_flush)
`endif
  );

  task automatic do_reset(input logic h);
    rst = 1'b1;
    hazard = h;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    hazard = 1'b0;
    mpc = 32'd0;
    cur = '{NOP, 32'd0, 1'b0};
    exp_q.delete();
    exp_stall = 0;
    exp_flush = 0;
  endtask

  // drive one cycle and push the IF/ID contents expected after it
  task automatic step(input logic h, input logic b, input logic [31:0] ba);
    hazard = h;
    branch = b;
    baddr = ba;
    if (b) begin
      exp_q.push_back('{NOP, 32'd0, 1'b0});
      mpc = {ba[31:2], 2'b00};
      if (exp_flush < (1 << CW) - 1) exp_flush++;
    end else if (!h) begin
      exp_q.push_back('{mem(mpc), mpc + 32'd4, 1'b1});
      mpc = mpc + 32'd4;
    end else begin
      exp_q.push_back(cur);
      if (exp_stall < (1 << CW) - 1) exp_stall++;
    end
    @(posedge clk);
    @(negedge clk);
    hazard = 1'b0;
    branch = 1'b0;
  endtask

  task automatic test_reset;
    do_reset(1'b0);
    checks += 4;
    if (imem_addr !== 32'd0) begin
      errors++;
      $display("FAIL rst_addr: got %h expected %h", imem_addr, 32'd0);
    end
    if (id_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid: got %b expected 0", id_valid);
    end
    if (id_instruction !== NOP) begin
      errors++;
      $display("FAIL rst_instr: got %h expected %h", id_instruction, NOP);
    end
    if (w_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_rst_addr: got %h expected fffffffc", w_addr);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (stall_count !== '0 || flush_count !== '0) begin
      errors++;
      $display("FAIL rst_cnt: got %0d/%0d expected 0/0", stall_count, flush_count);
    end
`endif
  endtask

  task automatic test_wrap;
    // wrap instance advanced exactly one cycle since test_reset
    checks += 3;
    if (w_addr !== 32'd0) begin
      errors++;
      $display("FAIL wrap_addr: got %h expected 0", w_addr);
    end
    if (w_pc !== 32'd0) begin
      errors++;
      $display("FAIL wrap_id_pc: got %h expected 0", w_pc);
    end
    if (w_instr !== mem(32'hFFFF_FFFC) || w_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_instr: got %h/%b expected %h/1",
               w_instr, w_valid, mem(32'hFFFF_FFFC));
    end
  endtask

  task automatic test_sequential(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 32'd0);
      cur = exp_q.pop_front();
      checks += 2;
      if (imem_addr !== mpc) begin
        errors++;
        $display("FAIL seq_addr: got %h expected %h", imem_addr, mpc);
      end
      if ({id_instruction, id_pc, id_valid} !== cur) begin
        errors++;
        $display("FAIL seq_ifid: got %h/%h/%b expected %h/%h/%b",
                 id_instruction, id_pc, id_valid, cur.instr, cur.pc, cur.valid);
      end
    end
  endtask

  task automatic test_freeze;
    do_reset(1'b0);
    test_sequential(2);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 32'd0);
      cur = exp_q.pop_front();
      checks += 2;
      if (imem_addr !== 32'h8) begin
        errors++;
        $display("FAIL frz_addr: got %h expected 00000008", imem_addr);
      end
      if ({id_instruction, id_pc, id_valid} !== cur || id_pc !== 32'h8) begin
        errors++;
        $display("FAIL frz_ifid: got %h/%h expected %h/%h",
                 id_instruction, id_pc, cur.instr, cur.pc);
      end
    end
    test_sequential(1);
    checks++;
    if (id_instruction !== mem(32'h8) || id_pc !== 32'hC) begin
      errors++;
      $display("FAIL frz_release: got %h/%h expected %h/0000000c",
               id_instruction, id_pc, mem(32'h8));
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (stall_count !== 4'd3) begin
      errors++;
      $display("FAIL frz_cnt: got %0d expected 3", stall_count);
    end
`endif
  endtask

  task automatic test_branch(input logic h, input logic [31:0] ba);
    step(h, 1'b1, ba);
    cur = exp_q.pop_front();
    checks += 2;
    if (imem_addr !== {ba[31:2], 2'b00}) begin
      errors++;
      $display("FAIL br_addr: got %h expected %h", imem_addr, {ba[31:2], 2'b00});
    end
    if (id_valid !== 1'b0 || id_instruction !== NOP || id_pc !== 32'd0) begin
      errors++;
      $display("FAIL br_flush: got %h/%h/%b expected %h/0/0",
               id_instruction, id_pc, id_valid, NOP);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (stall_count !== CW'(exp_stall) || flush_count !== CW'(exp_flush)) begin
      errors++;
      $display("FAIL br_cnt: got %0d/%0d expected %0d/%0d",
               stall_count, flush_count, exp_stall, exp_flush);
    end
`endif
    test_sequential(1);
    checks++;
    if (id_pc !== {ba[31:2], 2'b00} + 32'd4) begin
      errors++;
      $display("FAIL br_target: got %h expected %h", id_pc, {ba[31:2], 2'b00} + 32'd4);
    end
  endtask

  task automatic test_saturate;
    do_reset(1'b0);
    test_sequential(1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'd0);
    while (exp_q.size() > 0) cur = exp_q.pop_front();
    checks++;
    if (imem_addr !== 32'h4 || id_pc !== 32'h4) begin
      errors++;
      $display("FAIL sat_hold: got %h/%h expected 4/4", imem_addr, id_pc);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (stall_count !== 4'hF) begin
      errors++;
      $display("FAIL sat_cnt: got %0d expected 15", stall_count);
    end
`endif
  endtask

  task automatic test_rst_mid_stall;
    hazard = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    hazard = 1'b0;
    checks++;
    if (imem_addr !== 32'd0 || id_valid !== 1'b0 ||
        id_instruction !== NOP || id_pc !== 32'd0) begin
      errors++;
      $display("FAIL rst_stall: got %h/%h/%h/%b expected 0/%h/0/0",
               imem_addr, id_instruction, id_pc, id_valid, NOP);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (stall_count !== '0) begin
      errors++;
      $display("FAIL rst_stall_cnt: got %0d expected 0", stall_count);
    end
`endif
    mpc = 32'd0;
    cur = '{NOP, 32'd0, 1'b0};
    exp_q.delete();
    exp_stall = 0;
    exp_flush = 0;
  endtask

  task automatic test_back_to_back;
    logic h, b;
    logic [31:0] ba;
    for (int i = 0; i < 60; i++) begin
      h = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 6) == 0);
      ba = $urandom;
      step(h, b, ba);
      cur = exp_q.pop_front();
      checks += 2;
      if (imem_addr !== mpc) begin
        errors++;
        $display("FAIL b2b_addr: got %h expected %h", imem_addr, mpc);
      end
      if ({id_instruction, id_pc, id_valid} !== cur) begin
        errors++;
        $display("FAIL b2b_ifid: got %h/%h/%b expected %h/%h/%b",
                 id_instruction, id_pc, id_valid, cur.instr, cur.pc, cur.valid);
      end
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (stall_count !== CW'(exp_stall) || flush_count !== CW'(exp_flush)) begin
      errors++;
      $display("FAIL b2b_cnt: got %0d/%0d expected %0d/%0d",
               stall_count, flush_count, exp_stall, exp_flush);
    end
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_sequential(1);
    test_wrap();
    test_sequential(4);
    test_freeze();
    test_sequential(6);
    test_branch(1'b0, 32'h0000_0103);
    test_branch(1'b1, 32'h0000_0202);
    test_saturate();
    test_rst_mid_stall();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
